// File: rtl/id_ex_stage_if.sv
// Decoded-instruction bus: one instance carries ID fields into the stage,
// another carries the registered ID/EX fields out to execute/forwarding.
// Ports: master drives every field, slave samples every field.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            uses_rs1;
  logic            uses_rs2;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [3:0]      alu_op;
  logic            alu_src;
  logic            mem_read;
  logic            mem_write;
  logic            reg_write;
  logic            mem_to_reg;
  logic            branch;
  logic            jump;

  modport master (
    output valid, pc, imm, rs1, rs2, rd, uses_rs1, uses_rs2, rs1_data, rs2_data,
           alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
  );

  modport slave (
    input  valid, pc, imm, rs1, rs2, rd, uses_rs1, uses_rs2, rs1_data, rs2_data,
           alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble insertion, branch flush and WB bypass.
// Latency: one cycle ID -> ID/EX; stall_if_id is combinational in the same cycle as the ID inputs.
// Backpressure: mem_stall freezes everything; a load-use hazard holds IF/ID and injects one bubble.
// Ports: clk/rst; id (slave bus from decode); wb_* register-file write port; ex_flush; mem_stall;
//        stall_if_id; id_ex (master bus to execute/forwarding); load_use_count, flush_count.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     id,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_flush,
  input  logic             mem_stall,
  output logic             stall_if_id,
  id_ex_stage_if.master    id_ex,
  output logic [CNT_W-1:0] load_use_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            mem_to_reg;
    logic            branch;
    logic            jump;
  } stage_t;

  stage_t          st;
  stage_t          cap;
  logic            lu;
  logic            byp_rs1;
  logic            byp_rs2;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] fl_cnt;

  // The register file writes at the end of this cycle, so a same-cycle read
  // would see stale data; forward the write value instead. x0 is never bypassed.
  assign byp_rs1 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id.rs1);
  assign byp_rs2 = wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id.rs2);

  // A load in EX cannot forward its data to an ID consumer in time.
  assign lu = id.valid && st.valid && st.mem_read && (st.rd != 5'd0) &&
              ((id.uses_rs1 && (id.rs1 == st.rd)) ||
               (id.uses_rs2 && (id.rs2 == st.rd)));

  // A flush discards the wrong-path ID instruction, so there is nothing to hold.
  assign stall_if_id = mem_stall || (lu && !ex_flush);

  always_comb begin
    cap            = '0;
    cap.valid      = id.valid;
    cap.pc         = id.pc;
    cap.imm        = id.imm;
    cap.rs1        = id.rs1;
    cap.rs2        = id.rs2;
    cap.rd         = id.rd;
    cap.uses_rs1   = id.uses_rs1;
    cap.uses_rs2   = id.uses_rs2;
    cap.rs1_data   = byp_rs1 ? wb_data : id.rs1_data;
    cap.rs2_data   = byp_rs2 ? wb_data : id.rs2_data;
    cap.alu_op     = id.alu_op;
    cap.alu_src    = id.alu_src;
    cap.mem_read   = id.mem_read;
    cap.mem_write  = id.mem_write;
    cap.reg_write  = id.reg_write;
    cap.mem_to_reg = id.mem_to_reg;
    cap.branch     = id.branch;
    cap.jump       = id.jump;
  end

  // A bubble is all-zero: invalid, no control side effects, and rs/rd of 0
  // so the forwarding unit never matches it.
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= '0;
      lu_cnt <= '0;
      fl_cnt <= '0;
    end else if (mem_stall) begin
      // hold everything; a pending ex_flush is re-raised by the branch still in EX
      st     <= st;
    end else if (ex_flush) begin
      st <= '0;
      if (fl_cnt != {CNT_W{1'b1}}) fl_cnt <= fl_cnt + CNT_W'(1);
    end else if (lu) begin
      st <= '0;
      if (lu_cnt != {CNT_W{1'b1}}) lu_cnt <= lu_cnt + CNT_W'(1);
    end else begin
      st <= cap;
    end
  end

  assign load_use_count = lu_cnt;
  assign flush_count    = fl_cnt;

  assign id_ex.valid      = st.valid;
  assign id_ex.pc         = st.pc;
  assign id_ex.imm        = st.imm;
  assign id_ex.rs1        = st.rs1;
  assign id_ex.rs2        = st.rs2;
  assign id_ex.rd         = st.rd;
  assign id_ex.uses_rs1   = st.uses_rs1;
  assign id_ex.uses_rs2   = st.uses_rs2;
  assign id_ex.rs1_data   = st.rs1_data;
  assign id_ex.rs2_data   = st.rs2_data;
  assign id_ex.alu_op     = st.alu_op;
  assign id_ex.alu_src    = st.alu_src;
  assign id_ex.mem_read   = st.mem_read;
  assign id_ex.mem_write  = st.mem_write;
  assign id_ex.reg_write  = st.reg_write;
  assign id_ex.mem_to_reg = st.mem_to_reg;
  assign id_ex.branch     = st.branch;
  assign id_ex.jump       = st.jump;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with load-use hazard detection, bubble insertion, branch flush and register-file write-through bypass. It captures decoded instructions from the decode stage and presents them to the execute stage. Its registered `id_ex_rs1`, `id_ex_rs2`, `id_ex_rd` and `id_ex_reg_write` outputs are the source and destination fields the forwarding unit compares against EX/MEM and MEM/WB. It also raises the stall that freezes PC and IF/ID whenever forwarding cannot cover a hazard.

## Interface
- `XLEN`, 32, datapath width
- `CNT_W`, 16, width of the hazard performance counters

Ports:
- `clk` in 1 — clock, all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `id_valid` in 1 — decode stage holds a real instruction
- `id_pc`, `id_imm` in XLEN — PC and sign-extended immediate
- `id_rs1`, `id_rs2`, `id_rd` in 5 each — register indices
- `id_uses_rs1`, `id_uses_rs2` in 1 each — instruction actually reads rs1 / rs2
- `id_rs1_data`, `id_rs2_data` in XLEN — raw register-file read data
- `id_alu_op` in 4; `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch`, `id_jump` in 1 each — control fields
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_data` in XLEN — write-back port, written into the register file this cycle
- `ex_flush` in 1 — taken branch or jump resolved in EX
- `mem_stall` in 1 — downstream memory stall; freezes the whole pipeline
- `stall_if_id` out 1 — hold PC and IF/ID (combinational)
- `id_ex_valid` out 1, plus `id_ex_*` out — registered copies of every `id_*` field above, data fields after bypass
- `load_use_count`, `flush_count` out CNT_W — saturating event counters

## Operation
- Write-through bypass, combinational, before capture:
  - rs1 data = `wb_data` if `wb_reg_write && wb_rd != 0 && wb_rd == id_rs1`; otherwise `id_rs1_data`.
  - rs2 data follows the same rule against `id_rs2`.
  - Index 0 always passes `id_rsN_data` unchanged.
- Load-use hazard `lu` is asserted when all of the following hold:
  - `id_valid`, `id_ex_valid`, `id_ex_mem_read` and `id_ex_rd != 0`;
  - and either (`id_uses_rs1 && id_rs1 == id_ex_rd`) or (`id_uses_rs2 && id_rs2 == id_ex_rd`).
- Bubble = `id_ex_valid` 0, every control bit 0, and `id_ex_rs1`/`rs2`/`rd` 0 so that forwarding never matches it. PC, data and imm are don't-care but are driven 0.
- Next-state priority, evaluated each edge:
  1. `rst`: ID/EX becomes a bubble, both counters become 0.
  2. `mem_stall`: hold all ID/EX contents and counters. `ex_flush` is ignored this cycle; the branch stays in EX and reasserts it.
  3. `ex_flush`: load a bubble; `flush_count` +1.
  4. `lu`: load a bubble; `load_use_count` +1.
  5. Otherwise: capture the ID fields, with `id_ex_valid` = `id_valid`.
- `stall_if_id` = `mem_stall || (lu && !ex_flush)`. A flush wins over a load-use hazard because the ID instruction is wrong-path and is being discarded.
- Both counters saturate at 2^CNT_W−1 and do not wrap.
- An instruction with `id_valid`=0 never triggers `lu`.

## Timing
- Latency is one cycle from ID inputs to `id_ex_*` outputs.
- `stall_if_id` is combinational, same cycle as the ID inputs; it is asserted for exactly one cycle per load-use (the load then moves to MEM and `lu` clears).
- Reset values: all `id_ex_*` 0, `id_ex_valid` 0, both counters 0. `stall_if_id` follows its equation; it is 0 during reset unless `mem_stall` is asserted.
- Reset asserted mid-stall produces a bubble on the next edge regardless of `mem_stall`.
- A stalled ID instruction is re-presented by the upstream hold and captured on the following edge; it must be captured exactly once.

## Test plan
- Load x5 then `add x6,x5,x1`: stall 1 cycle → `stall_if_id`=1 for one cycle, one bubble (`id_ex_valid`=0, rd=0), then the add is captured, `load_use_count`=1.
- Load x5 then `lui x5` (uses neither rs1 nor rs2): `lu`=0, no stall, no bubble.
- Load x0 then `add x6,x0,x0`: no stall.
- Load-use and `ex_flush` asserted in the same cycle → `stall_if_id`=0, bubble loaded, `flush_count`=1, `load_use_count`=0.
- `wb_rd`=7, `wb_data`=0xDEADBEEF, `id_rs2`=7, `id_rs2_data`=0 → `id_ex_rs2_data`=0xDEADBEEF next cycle. With `wb_rd`=0 the raw data passes instead.
- `mem_stall` held 3 cycles with `ex_flush`=1 → ID/EX unchanged and `flush_count` unchanged. `CNT_W`=2 with 5 flushes → `flush_count`=3 (saturated). `rst` pulse → all outputs 0.
